// File: rtl/or_window_accum.sv
// Windowed sticky-OR collector: ORs accepted beats together and emits one word per WINDOW beats or per flush.
// Optional feature macro: OR_ACCUM_PARITY_EN adds out_parity = ^O, registered with O.
module or_window_accum #(
    parameter int  WIDTH  = 4,
    parameter int  WINDOW = 8,
    localparam int CW     = $clog2(WINDOW + 1)
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [WIDTH-1:0] I,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] O,
    output logic [CW-1:0]    out_count,
    output logic             out_partial,
    output logic             out_valid,
    input  logic             out_ready
`ifdef OR_ACCUM_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_STALLED = 2'd2
    } acc_state_e;

    localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WINDOW);

`ifdef OR_ACCUM_PARITY_EN
    function automatic logic parity_f(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic [CW-1:0]    out_count_q, out_count_d;
    logic             out_partial_q, out_partial_d;
    logic             out_valid_q, out_valid_d;
`ifdef OR_ACCUM_PARITY_EN
    logic             out_parity_q, out_parity_d;
`endif

    acc_state_e       state_s;
    logic             accept_s;
    logic [WIDTH-1:0] nacc_s;
    logic [CW-1:0]    ncnt_s;
    logic             slot_free_s;
    logic             full_close_s;
    logic             flush_close_s;

    // State decode from the count and the output slot; STALLED wins when WINDOW==1 overlaps EMPTY.
    always_comb begin
        state_s = ST_EMPTY;
        if (out_valid_q && (cnt_q == CNT_LAST)) begin
            state_s = ST_STALLED;
        end else if (cnt_q != {CW{1'b0}}) begin
            state_s = ST_FILLING;
        end else begin
            state_s = ST_EMPTY;
        end
    end

    assign in_ready = (state_s != ST_STALLED);

    // Next-state: accumulate, close on a full window or on flush, drain the output slot.
    always_comb begin
        accept_s      = in_valid && in_ready;
        nacc_s        = acc_q | (accept_s ? I : {WIDTH{1'b0}});
        ncnt_s        = cnt_q + CW'(accept_s);
        slot_free_s   = !out_valid_q || out_ready;
        full_close_s  = accept_s && (ncnt_s == CNT_FULL);
        flush_close_s = flush && (ncnt_s != {CW{1'b0}}) && slot_free_s && !full_close_s;

        acc_d         = nacc_s;
        cnt_d         = ncnt_s;
        o_d           = o_q;
        out_count_d   = out_count_q;
        out_partial_d = out_partial_q;
        out_valid_d   = out_valid_q && !out_ready;
`ifdef OR_ACCUM_PARITY_EN
        out_parity_d  = out_parity_q;
`endif

        if (full_close_s || flush_close_s) begin
            acc_d         = {WIDTH{1'b0}};
            cnt_d         = {CW{1'b0}};
            o_d           = nacc_s;
            out_count_d   = full_close_s ? CNT_FULL : ncnt_s;
            out_partial_d = !full_close_s;
            out_valid_d   = 1'b1;
`ifdef OR_ACCUM_PARITY_EN
            out_parity_d  = parity_f(nacc_s);
`endif
        end else begin
            acc_d = nacc_s;
            cnt_d = ncnt_s;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            acc_q         <= {WIDTH{1'b0}};
            cnt_q         <= {CW{1'b0}};
            o_q           <= {WIDTH{1'b0}};
            out_count_q   <= {CW{1'b0}};
            out_partial_q <= 1'b0;
            out_valid_q   <= 1'b0;
`ifdef OR_ACCUM_PARITY_EN
            out_parity_q  <= 1'b0;
`endif
        end else begin
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            o_q           <= o_d;
            out_count_q   <= out_count_d;
            out_partial_q <= out_partial_d;
            out_valid_q   <= out_valid_d;
`ifdef OR_ACCUM_PARITY_EN
            out_parity_q  <= out_parity_d;
`endif
        end
    end

    assign O           = o_q;
    assign out_count   = out_count_q;
    assign out_partial = out_partial_q;
    assign out_valid   = out_valid_q;
`ifdef OR_ACCUM_PARITY_EN
    assign out_parity  = out_parity_q;
`endif

endmodule

// File: tb/tb_or_window_accum.sv
// Directed bench for or_window_accum (WIDTH=4, WINDOW=4) with an expected-word queue,
// plus a WINDOW=1 instance sharing the same stimulus.
module tb_or_window_accum;

    logic       CLK = 1'b0;
    logic       ASYNCRESET = 1'b0;
    logic [3:0] I = 4'd0;
    logic       in_valid = 1'b0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_partial, out_valid;
    logic [3:0] O;
    logic [2:0] out_count;
    logic       in_ready1, out_partial1, out_valid1;
    logic [3:0] O1;
    logic [0:0] out_count1;
`ifdef OR_ACCUM_PARITY_EN
    logic       out_parity, out_parity1;
`endif

    or_window_accum #(.WIDTH(4), .WINDOW(4)) u_dut (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .I(I), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .O(O), .out_count(out_count), .out_partial(out_partial),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef OR_ACCUM_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    or_window_accum #(.WIDTH(4), .WINDOW(1)) u_dut1 (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .I(I), .in_valid(in_valid), .in_ready(in_ready1),
        .flush(flush), .O(O1), .out_count(out_count1), .out_partial(out_partial1),
        .out_valid(out_valid1), .out_ready(out_ready)
`ifdef OR_ACCUM_PARITY_EN
        , .out_parity(out_parity1)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] o;
        logic [2:0] cnt;
        logic       part;
    } word_t;

    word_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample on the falling edge; any word transferred there is checked against the queue head.
    task automatic tick();
        @(negedge CLK);
        if (out_valid && out_ready) begin
            chk("word_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() != 0) begin
                word_t w;
                w = exp_q.pop_front();
                chk("word_O", O, w.o);
                chk("word_count", out_count, w.cnt);
                chk("word_partial", out_partial, w.part);
`ifdef OR_ACCUM_PARITY_EN
                chk("word_parity", out_parity, ^w.o);
`endif
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [3:0] t1 [4];
        logic [3:0] w1 [3];
        t1 = '{4'b0001, 4'b0010, 4'b0000, 4'b1000};
        w1 = '{4'b0101, 4'b1010, 4'b0011};

        // Reset state, no clock edge needed
        #1 ASYNCRESET = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_O", O, 4'd0);
        chk("rst_count", out_count, 3'd0);
        chk("rst_partial", out_partial, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_w1_out_valid", out_valid1, 1'b0);
        @(posedge CLK);
        #1 ASYNCRESET = 1'b0;

        // 1. Full window with out_ready=1
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            I = t1[i];
            in_valid = 1'b1;
            chk("t1_in_ready", in_ready, 1'b1);
            if (i == 3) exp_q.push_back('{o: 4'b1011, cnt: 3'd4, part: 1'b0});
            tick();
            if (i < 3) chk("t1_no_early_valid", out_valid, 1'b0);
        end
        in_valid = 1'b0;
        chk("t1_valid_rise", out_valid, 1'b1);
        tick();
        chk("t1_one_cycle", out_valid, 1'b0);

        // 2. Backpressure: 8 beats of 0001 with out_ready=0
        out_ready = 1'b0;
        I = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            chk("t2_in_ready", in_ready, 1'b1);
            if (i == 3) exp_q.push_back('{o: 4'b0001, cnt: 3'd4, part: 1'b0});
            tick();
        end
        chk("t2_stall_in_ready", in_ready, 1'b0);
        chk("t2_held_valid", out_valid, 1'b1);
        chk("t2_held_O", O, 4'b0001);
        chk("t2_held_count", out_count, 3'd4);
        tick();
        chk("t2_still_stalled", in_ready, 1'b0);
        chk("t2_still_O", O, 4'b0001);
        chk("t2_still_count", out_count, 3'd4);
        out_ready = 1'b1;
        chk("t2_no_comb_ready_path", in_ready, 1'b0);
        exp_q.push_back('{o: 4'b0001, cnt: 3'd4, part: 1'b0});
        tick();
        chk("t2_resume_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t2_drained", out_valid, 1'b0);

        // 3. Flush of a partial window, then flush with nothing accumulated
        I = 4'b0100; in_valid = 1'b1; tick();
        I = 4'b0001; tick();
        in_valid = 1'b0;
        flush = 1'b1;
        exp_q.push_back('{o: 4'b0101, cnt: 3'd2, part: 1'b1});
        tick();
        chk("t3_flush_valid", out_valid, 1'b1);
        tick();
        chk("t3_empty_flush_none", out_valid, 1'b0);
        tick();
        chk("t3_empty_flush_none2", out_valid, 1'b0);
        flush = 1'b0;

        // 4. Flush coincident with a beat
        I = 4'b0010; in_valid = 1'b1; tick();
        I = 4'b1000; flush = 1'b1;
        exp_q.push_back('{o: 4'b1010, cnt: 3'd2, part: 1'b1});
        tick();
        in_valid = 1'b0; flush = 1'b0;
        tick();
        chk("t4_drained", out_valid, 1'b0);

        // 5. Asynchronous reset mid-window with a word pending
        out_ready = 1'b0;
        I = 4'b0110; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        in_valid = 1'b0;
        chk("t5_pre_valid", out_valid, 1'b1);
        #1 ASYNCRESET = 1'b1;
        #1;
        chk("t5_rst_valid", out_valid, 1'b0);
        chk("t5_rst_O", O, 4'd0);
        chk("t5_rst_count", out_count, 3'd0);
        chk("t5_rst_in_ready", in_ready, 1'b1);
        #1 ASYNCRESET = 1'b0;
        tick();
        out_ready = 1'b1;
        I = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            if (i == 3) exp_q.push_back('{o: 4'b1111, cnt: 3'd4, part: 1'b0});
            tick();
            if (i < 3) chk("t5_cnt_cleared", out_valid, 1'b0);
        end
        in_valid = 1'b0;
        tick();

        // 6. Windows with odd and even parity, back to back
        in_valid = 1'b1;
        I = 4'b0001; tick();
        I = 4'b0010; tick();
        I = 4'b0100; tick();
        I = 4'b0000;
        exp_q.push_back('{o: 4'b0111, cnt: 3'd4, part: 1'b0});
        tick();
        I = 4'b0101; tick();
        I = 4'b0000; tick();
        tick();
        exp_q.push_back('{o: 4'b0101, cnt: 3'd4, part: 1'b0});
        tick();
        in_valid = 1'b0;
        tick();
        tick();

        // WINDOW=1 instance: every accepted beat is emitted alone
        for (int i = 0; i < 3; i++) begin
            I = w1[i];
            in_valid = 1'b1;
            chk("w1_in_ready", in_ready1, 1'b1);
            tick();
            in_valid = 1'b0;
            chk("w1_valid", out_valid1, 1'b1);
            chk("w1_O", O1, w1[i]);
            chk("w1_count", out_count1, 1'b1);
            chk("w1_partial", out_partial1, 1'b0);
`ifdef OR_ACCUM_PARITY_EN
            chk("w1_parity", out_parity1, ^w1[i]);
`endif
            tick();
            chk("w1_drained", out_valid1, 1'b0);
        end

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
